// File: rtl/alu_pkg.sv
// Shared ALU-path types and sizes.
// Result width, display digit count and the BCD converter state encoding.
package alu_pkg;

  localparam int RESULT_WIDTH = 9;
  localparam int BCD_DIGITS   = 3;

  typedef enum logic {
    IDLE,
    CONVERT
  } conv_state_e;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble nibble correction: adds 3 when the digit is 5 or more.
// Ports: din (4-bit BCD digit), dout (corrected digit, ready to shift).
module bcd_digit_adjust (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end

endmodule

// File: rtl/result_bcd_converter.sv
// Iterative binary-to-BCD converter for the ALU result, one bit per clock.
// Ports: clk, reset (sync, active-high), start/value in; busy, done, bcd out.
module result_bcd_converter
  import alu_pkg::*;
#(
  parameter int WIDTH  = RESULT_WIDTH,
  parameter int DIGITS = BCD_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  conv_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;

  logic [BCD_W-1:0] adj;
  logic [SR_W-1:0]  shifted;

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (sr_q[WIDTH+4*gi +: 4]),
      .dout (adj[4*gi +: 4])
    );
  end

  // Adjusted digits plus binary field, shifted left by one.
  assign shifted = {adj[BCD_W-2:0], sr_q[WIDTH-1:0], 1'b0};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    bcd_d   = bcd_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sr_d    = {{BCD_W{1'b0}}, value};
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        sr_d  = shifted;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          bcd_d   = shifted[SR_W-1 -: BCD_W];
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bcd_q   <= bcd_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule
